// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// FSM state encoding and the bundle of per-register pipeline controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  typedef struct packed {
    logic freeze_pc_ifid;
    logic freeze_all;
    logic bubble_idexe;
    logic flush_ifid;
    logic flush_idexe;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-facing signal bundle of the stall/flush sequencer.
// master = pipeline/config side, slave = the sequencer itself.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             cfg_we;
  logic             cfg_fwd;
  logic             cnt_clr;

  logic             forward_en;
  logic             freeze_pc_ifid;
  logic             freeze_all;
  logic             bubble_idexe;
  logic             flush_ifid;
  logic             flush_idexe;
  logic             mem_timeout;
  logic [CNT_W-1:0] hz_stall_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard_detected,
    output branch_taken,
    output mem_req,
    output mem_ready,
    output cfg_we,
    output cfg_fwd,
    output cnt_clr,
    input  forward_en,
    input  freeze_pc_ifid,
    input  freeze_all,
    input  bubble_idexe,
    input  flush_ifid,
    input  flush_idexe,
    input  mem_timeout,
    input  hz_stall_cnt,
    input  mem_wait_cnt,
    input  flush_cnt
  );

  modport slave (
    input  hazard_detected,
    input  branch_taken,
    input  mem_req,
    input  mem_ready,
    input  cfg_we,
    input  cfg_fwd,
    input  cnt_clr,
    output forward_en,
    output freeze_pc_ifid,
    output freeze_all,
    output bubble_idexe,
    output flush_ifid,
    output flush_idexe,
    output mem_timeout,
    output hz_stall_cnt,
    output mem_wait_cnt,
    output flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    priority case (1'b1)
      clr:                   q_d = '0;
      (inc && (q_q != '1)):  q_d = q_q + W'(1);
      default:               q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: memory-wait watchdog FSM,
// priority control mux, forward_en config bit, perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave pif
);

  localparam int WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_e          state_q;
  state_e          state_d;
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            tmo_q;
  logic            tmo_d;
  logic            fwd_q;
  logic            fwd_d;
  logic            mem_stall;
  logic            wait_start;
  ctrl_t           ctrl;

  assign wait_start = pif.mem_req & ~pif.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      fwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      fwd_q   <= fwd_d;
    end
  end

  // wd_q counts frozen cycles already spent on the current access
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_RUN: begin
        if (wait_start) begin
          state_d = ST_MEM_WAIT;
          wd_d    = WD_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        priority case (1'b1)
          pif.mem_ready: begin
            state_d = ST_RUN;
            wd_d    = '0;
          end
          (wd_q == WD_LAST): begin
            state_d = ST_ERROR;
            tmo_d   = 1'b1;
          end
          default: wd_d = wd_q + WD_W'(1);
        endcase
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    unique case (state_q)
      ST_RUN:      mem_stall = wait_start;
      ST_MEM_WAIT: mem_stall = ~pif.mem_ready;
      default:     mem_stall = 1'b1;
    endcase
  end

  // A frozen pipeline keeps the branch in EXE; it flushes after release
  always_comb begin
    ctrl = CTRL_IDLE;
    priority case (1'b1)
      mem_stall: begin
        ctrl.freeze_all = 1'b1;
      end
      pif.branch_taken: begin
        ctrl.flush_ifid  = 1'b1;
        ctrl.flush_idexe = 1'b1;
      end
      pif.hazard_detected: begin
        ctrl.freeze_pc_ifid = 1'b1;
        ctrl.bubble_idexe   = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  always_comb begin
    fwd_d = fwd_q;
    if (pif.cfg_we) begin
      fwd_d = pif.cfg_fwd;
    end
  end

  assign pif.freeze_pc_ifid = ctrl.freeze_pc_ifid;
  assign pif.freeze_all     = ctrl.freeze_all;
  assign pif.bubble_idexe   = ctrl.bubble_idexe;
  assign pif.flush_ifid     = ctrl.flush_ifid;
  assign pif.flush_idexe    = ctrl.flush_idexe;
  assign pif.mem_timeout    = tmo_q;
  assign pif.forward_en     = fwd_q;

  sat_counter #(
    .W (CNT_W)
  ) u_hz_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.bubble_idexe),
    .clr (pif.cnt_clr),
    .q   (pif.hz_stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_mw_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.freeze_all),
    .clr (pif.cnt_clr),
    .q   (pif.mem_wait_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_fl_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.flush_ifid),
    .clr (pif.cnt_clr),
    .q   (pif.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random
// traffic checked against a cycle-count reference model.
module tb_pipeline_ctrl;

  localparam int MT   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) pif ();

  pipeline_ctrl #(
    .MEM_TIMEOUT (MT),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  int npass = 0;
  int ntot  = 0;

  int m_n;
  int m_hz;
  int m_mw;
  int m_fl;
  bit m_err;
  bit m_fwd;

  function automatic int sat(int c, bit ev, bit clr);
    if (clr) return 0;
    if (ev && c < CMAX) return c + 1;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic drive(input bit hz, br, rq, rdy, we, fwd, clr);
    pif.hazard_detected = hz;
    pif.branch_taken    = br;
    pif.mem_req         = rq;
    pif.mem_ready       = rdy;
    pif.cfg_we          = we;
    pif.cfg_fwd         = fwd;
    pif.cnt_clr         = clr;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".hz_cnt"}, 32'(pif.hz_stall_cnt), 32'(m_hz));
    chk({tag, ".mw_cnt"}, 32'(pif.mem_wait_cnt), 32'(m_mw));
    chk({tag, ".fl_cnt"}, 32'(pif.flush_cnt), 32'(m_fl));
    chk({tag, ".fwd"}, 32'(pif.forward_en), 32'(m_fwd));
    chk({tag, ".tmo"}, 32'(pif.mem_timeout), 32'(m_err));
  endtask

  task automatic chk_ctrl(input string tag, input bit st, fl, bub);
    chk({tag, ".frz_all"}, 32'(pif.freeze_all), 32'(st));
    chk({tag, ".fl_ifid"}, 32'(pif.flush_ifid), 32'(fl));
    chk({tag, ".fl_idexe"}, 32'(pif.flush_idexe), 32'(fl));
    chk({tag, ".bubble"}, 32'(pif.bubble_idexe), 32'(bub));
    chk({tag, ".frz_pc"}, 32'(pif.freeze_pc_ifid), 32'(bub));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    m_n   = 0;
    m_hz  = 0;
    m_mw  = 0;
    m_fl  = 0;
    m_err = 0;
    m_fwd = 0;
    chk_ctrl(tag, 0, 0, 0);
    chk_regs(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // A memory access stalls until ready; MT stalled cycles without
  // ready lock the controller up until reset.
  task automatic step(input string tag,
                      input bit hz, br, rq, rdy, we, fwd, clr);
    bit e_st;
    bit e_fl;
    bit e_bub;
    drive(hz, br, rq, rdy, we, fwd, clr);
    #2;
    e_st  = m_err || (!rdy && (m_n > 0 || rq));
    e_fl  = !e_st && br;
    e_bub = !e_st && !br && hz;
    chk_ctrl(tag, e_st, e_fl, e_bub);
    @(posedge clk);
    if (!m_err) begin
      if (e_st) begin
        m_n++;
        if (m_n >= MT) m_err = 1;
      end else begin
        m_n = 0;
      end
    end
    m_hz = sat(m_hz, e_bub, clr);
    m_mw = sat(m_mw, e_st, clr);
    m_fl = sat(m_fl, e_fl, clr);
    if (we) m_fwd = fwd;
    #1;
    chk_regs(tag);
  endtask

  initial begin
    #1;
    do_reset("reset");

    step("hz1", 1, 0, 0, 0, 0, 0, 0);
    step("hz2", 1, 0, 0, 0, 0, 0, 0);
    chk("hz_cnt_is_2", 32'(pif.hz_stall_cnt), 32'd2);

    step("br_hz", 1, 1, 0, 0, 0, 0, 0);
    chk("fl_cnt_is_1", 32'(pif.flush_cnt), 32'd1);

    step("mw1", 0, 1, 1, 0, 0, 0, 0);
    step("mw2", 0, 1, 1, 0, 0, 0, 0);
    step("mw3", 0, 1, 1, 0, 0, 0, 0);
    step("mw4", 0, 1, 1, 1, 0, 0, 0);
    chk("mw_cnt_is_3", 32'(pif.mem_wait_cnt), 32'd3);
    chk("fl_cnt_is_2", 32'(pif.flush_cnt), 32'd2);

    step("zero_wait", 0, 0, 1, 1, 0, 0, 1);
    step("to1", 0, 0, 1, 0, 0, 0, 0);
    step("to2", 0, 0, 1, 0, 0, 0, 0);
    step("to3", 0, 0, 1, 0, 0, 0, 0);
    step("to4", 0, 0, 1, 0, 0, 0, 0);
    chk("timeout_set", 32'(pif.mem_timeout), 32'd1);
    step("late_rdy", 1, 1, 1, 1, 0, 0, 0);
    step("err_idle", 0, 0, 0, 0, 1, 1, 0);
    chk("err_frozen", 32'(pif.freeze_all), 32'd1);
    do_reset("err_reset");

    for (int i = 0; i < 5; i++) begin
      step("sat_hz", 1, 0, 0, 0, 0, 0, 0);
    end
    chk("hz_cnt_sat", 32'(pif.hz_stall_cnt), 32'(CMAX));
    step("clr_hz", 1, 0, 0, 0, 0, 0, 1);
    chk("hz_cnt_clr", 32'(pif.hz_stall_cnt), 32'd0);
    step("cfg_fwd", 0, 0, 0, 0, 1, 1, 0);
    chk("fwd_set", 32'(pif.forward_en), 32'd1);

    for (int i = 0; i < 400; i++) begin
      if (m_err ? ($urandom % 6 == 0) : ($urandom % 150 == 0)) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom % 3) == 0,
             ($urandom % 4) == 0,
             ($urandom % 3) == 0,
             ($urandom % 2) == 0,
             ($urandom % 8) == 0,
             ($urandom % 2) == 0,
             ($urandom % 16) == 0);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
